// File: rtl/gato_pkg.sv
// Shared types and helpers for the N x N tic-tac-toe engine.
// Line masks are built at elaboration time from the board side.
package gato_pkg;

    typedef enum logic [2:0] {
        START  = 3'd0,
        TURN_X = 3'd1,
        TURN_O = 3'd2,
        CHECK  = 3'd3,
        WIN_X  = 3'd4,
        WIN_O  = 3'd5,
        DRAW   = 3'd6
    } gato_state_t;

    localparam int MAX_N  = 8;
    localparam int MAX_SQ = MAX_N * MAX_N;

    // k < n: row k; k < 2n: column k-n; 2n: main diagonal; 2n+1: anti-diagonal
    function automatic logic [MAX_SQ-1:0] line_mask(input int n, input int k);
        logic [MAX_SQ-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) begin
            if (k < n)
                m[k*n + i] = 1'b1;
            else if (k < 2*n)
                m[i*n + (k - n)] = 1'b1;
            else if (k == 2*n)
                m[i*n + i] = 1'b1;
            else
                m[i*n + (n - 1 - i)] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/gato_line_check.sv
// Combinational full-line detector: any row, column or diagonal
// completely owned by the given board.
module gato_line_check
    import gato_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N*N-1:0] i_board,
    output logic           o_win
);

    localparam int NL = 2*N + 2;

    logic [NL-1:0] w_hit;

    for (genvar k = 0; k < NL; k++) begin : g_line
        localparam logic [MAX_SQ-1:0] FULL_MASK = line_mask(N, k);
        localparam logic [N*N-1:0]    MASK      = FULL_MASK[N*N-1:0];
        assign w_hit[k] = (i_board & MASK) == MASK;
    end

    assign o_win = |w_hit;

endmodule

// File: rtl/gato_nxn_engine.sv
// N x N tic-tac-toe round engine: board registers, turn FSM,
// per-turn timeout with auto-placement and saturating scores.
module gato_nxn_engine
    import gato_pkg::*;
#(
    parameter int N             = 3,
    parameter int SCORE_W       = 4,
    parameter int TIMEOUT_TICKS = 10,
    parameter int TMR_W         = 4
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               tick,
    input  logic               restart,
    input  logic               erase,
    input  logic               randomClick,
    input  logic [N*N-1:0]     cuadro,
    output logic [N*N-1:0]     x,
    output logic [N*N-1:0]     o,
    output logic [2:0]         state,
    output logic               turnoX,
    output logic               displayStartPlaying,
    output logic               displayGanadorX,
    output logic               displayGanadorO,
    output logic               displayEmpate,
    output logic [SCORE_W-1:0] score_x,
    output logic [SCORE_W-1:0] score_o,
    output logic               auto_move
);

    localparam int                 SQ        = N * N;
    localparam logic [SQ-1:0]      SQ_ONE    = SQ'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT_TICKS - 1);
    localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);

    function automatic logic [SQ-1:0] lowest_bit(input logic [SQ-1:0] v);
        return v & (~v + SQ_ONE);
    endfunction

    gato_state_t        r_state, w_state_nx;
    logic [SQ-1:0]      r_x, r_o, r_prev, w_x_nx, w_o_nx;
    logic [SCORE_W-1:0] r_sx, r_so, w_sx_nx, w_so_nx;
    logic [TMR_W-1:0]   r_timer, w_timer_nx;
    logic               r_starter_x, w_starter_nx;
    logic               r_mover_x, w_mover_nx;
    logic               r_auto, w_auto_nx;
    logic [SQ-1:0]      w_occ, w_cand, w_pick, w_mover_board;
    logic               w_win, w_full, w_terminal, w_do_auto;

    assign w_occ         = r_x | r_o;
    assign w_full        = &w_occ;
    assign w_cand        = cuadro & ~r_prev & ~w_occ;
    assign w_do_auto     = randomClick || (w_cand == '0 && r_timer == TMR_LAST);
    assign w_pick        = (!randomClick && w_cand != '0) ? lowest_bit(w_cand)
                                                          : lowest_bit(~w_occ);
    assign w_terminal    = r_state inside {WIN_X, WIN_O, DRAW};
    assign w_mover_board = r_mover_x ? r_x : r_o;

    gato_line_check #(.N(N)) u_line (
        .i_board (w_mover_board),
        .o_win   (w_win)
    );

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset)
            r_state <= START;
        else if (tick)
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx   = r_state;
        w_x_nx       = r_x;
        w_o_nx       = r_o;
        w_sx_nx      = r_sx;
        w_so_nx      = r_so;
        w_timer_nx   = r_timer;
        w_starter_nx = r_starter_x;
        w_mover_nx   = r_mover_x;
        w_auto_nx    = 1'b0;
        if (erase) begin
            w_state_nx   = START;
            w_x_nx       = '0;
            w_o_nx       = '0;
            w_sx_nx      = '0;
            w_so_nx      = '0;
            w_timer_nx   = '0;
            w_starter_nx = 1'b1;
        end else if (restart) begin
            w_state_nx = START;
            w_x_nx     = '0;
            w_o_nx     = '0;
            w_timer_nx = '0;
            // Alternate the opening player only when a round actually ended
            if (w_terminal)
                w_starter_nx = ~r_starter_x;
        end else begin
            unique case (r_state)
                START: begin
                    w_state_nx = r_starter_x ? TURN_X : TURN_O;
                    w_mover_nx = r_starter_x;
                    w_timer_nx = '0;
                end
                TURN_X, TURN_O: begin
                    w_mover_nx = (r_state == TURN_X);
                    if (w_cand != '0 || w_do_auto) begin
                        if (r_state == TURN_X)
                            w_x_nx = r_x | w_pick;
                        else
                            w_o_nx = r_o | w_pick;
                        w_auto_nx  = w_do_auto;
                        w_state_nx = CHECK;
                    end else begin
                        w_timer_nx = r_timer + TMR_ONE;
                    end
                end
                CHECK: begin
                    if (w_win) begin
                        if (r_mover_x) begin
                            w_state_nx = WIN_X;
                            if (r_sx != SCORE_MAX)
                                w_sx_nx = r_sx + 1'b1;
                        end else begin
                            w_state_nx = WIN_O;
                            if (r_so != SCORE_MAX)
                                w_so_nx = r_so + 1'b1;
                        end
                    end else if (w_full) begin
                        w_state_nx = DRAW;
                    end else begin
                        w_state_nx = r_mover_x ? TURN_O : TURN_X;
                        w_timer_nx = '0;
                    end
                end
                WIN_X, WIN_O, DRAW: ;
                default: w_state_nx = START;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            r_x         <= '0;
            r_o         <= '0;
            r_prev      <= '0;
            r_sx        <= '0;
            r_so        <= '0;
            r_timer     <= '0;
            r_starter_x <= 1'b1;
            r_mover_x   <= 1'b1;
            r_auto      <= 1'b0;
        end else if (tick) begin
            r_x         <= w_x_nx;
            r_o         <= w_o_nx;
            r_prev      <= cuadro;
            r_sx        <= w_sx_nx;
            r_so        <= w_so_nx;
            r_timer     <= w_timer_nx;
            r_starter_x <= w_starter_nx;
            r_mover_x   <= w_mover_nx;
            r_auto      <= w_auto_nx;
        end
    end

    always_comb begin
        displayStartPlaying = (r_state == START);
        displayGanadorX     = (r_state == WIN_X);
        displayGanadorO     = (r_state == WIN_O);
        displayEmpate       = (r_state == DRAW);
        turnoX              = r_mover_x;
        unique case (r_state)
            START:   turnoX = r_starter_x;
            TURN_X:  turnoX = 1'b1;
            TURN_O:  turnoX = 1'b0;
            default: turnoX = r_mover_x;
        endcase
    end

    assign x         = r_x;
    assign o         = r_o;
    assign state     = r_state;
    assign score_x   = r_sx;
    assign score_o   = r_so;
    assign auto_move = r_auto;

endmodule

// File: tb/tb_gato_nxn_engine.sv
// Directed bench: a 3x3 engine for game flow, timeout and edge rules,
// and a 4x4 engine with 2-bit scores for saturation and async reset.
module tb_gato_nxn_engine;

    logic        clk = 1'b0;
    logic        rst3, rst4, tick, restart, erase, rnd;
    logic [8:0]  c3, x3, o3;
    logic [15:0] c4, x4, o4;
    logic [2:0]  st3, st4;
    logic        tx3, dsp3, dgx3, dgo3, de3, am3;
    logic        tx4, dsp4, dgx4, dgo4, de4, am4;
    logic [3:0]  sx3, so3;
    logic [1:0]  sx4, so4;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gato_nxn_engine #(.N(3), .SCORE_W(4), .TIMEOUT_TICKS(10), .TMR_W(4)) u3 (
        .clk_100MHz(clk), .reset(rst3), .tick(tick), .restart(restart),
        .erase(erase), .randomClick(rnd), .cuadro(c3), .x(x3), .o(o3),
        .state(st3), .turnoX(tx3), .displayStartPlaying(dsp3),
        .displayGanadorX(dgx3), .displayGanadorO(dgo3), .displayEmpate(de3),
        .score_x(sx3), .score_o(so3), .auto_move(am3)
    );

    gato_nxn_engine #(.N(4), .SCORE_W(2), .TIMEOUT_TICKS(10), .TMR_W(4)) u4 (
        .clk_100MHz(clk), .reset(rst4), .tick(tick), .restart(restart),
        .erase(erase), .randomClick(rnd), .cuadro(c4), .x(x4), .o(o4),
        .state(st4), .turnoX(tx4), .displayStartPlaying(dsp4),
        .displayGanadorX(dgx4), .displayGanadorO(dgo4), .displayEmpate(de4),
        .score_x(sx4), .score_o(so4), .auto_move(am4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tk();
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic p3(input int sq);
        c3     = '0;
        c3[sq] = 1'b1;
        tk();
        c3 = '0;
        tk();
    endtask

    task automatic p4(input int sq);
        c4     = '0;
        c4[sq] = 1'b1;
        tk();
        c4 = '0;
        tk();
    endtask

    always @(negedge clk) begin
        chk("x_and_o_3", {23'd0, x3 & o3}, 32'd0);
        chk("x_and_o_4", {16'd0, x4 & o4}, 32'd0);
    end

    initial begin
        rst3 = 1'b0; rst4 = 1'b0; tick = 1'b0;
        restart = 1'b0; erase = 1'b0; rnd = 1'b0;
        c3 = '0; c4 = '0;
        #12;
        chk("rst_state", 32'(st3), 32'd0);
        chk("rst_start", 32'(dsp3), 32'd1);
        chk("rst_turnoX", 32'(tx3), 32'd1);
        chk("rst_x", 32'(x3), 32'd0);
        chk("rst_score", 32'({sx3, so3}), 32'd0);
        @(negedge clk);
        rst3 = 1'b1;

        // Game 1: X wins the top row
        tk();
        chk("g1_turn_x", 32'(st3), 32'd1);
        c3 = 9'b000000001;
        tk();
        chk("g1_lat_state", 32'(st3), 32'd3);
        chk("g1_lat_x", 32'(x3), 32'h001);
        chk("g1_lat_turnoX", 32'(tx3), 32'd1);
        c3 = '0;
        tk();
        chk("g1_turn_o", 32'(st3), 32'd2);
        chk("g1_turnoX_o", 32'(tx3), 32'd0);
        p3(4); p3(1); p3(5); p3(2);
        chk("g1_win_state", 32'(st3), 32'd4);
        chk("g1_win_x", 32'(x3), 32'h007);
        chk("g1_win_o", 32'(o3), 32'h030);
        chk("g1_score_x", 32'(sx3), 32'd1);
        chk("g1_disp_x", 32'(dgx3), 32'd1);

        // Restart after the win hands the opening move to O
        restart = 1'b1;
        tk();
        restart = 1'b0;
        chk("rs_state", 32'(st3), 32'd0);
        chk("rs_board", 32'({x3, o3}), 32'd0);
        tk();
        chk("rs_turn_o", 32'(st3), 32'd2);
        chk("rs_score_x", 32'(sx3), 32'd1);

        // erase beats restart: scores cleared and X opens again
        erase = 1'b1; restart = 1'b1;
        tk();
        erase = 1'b0; restart = 1'b0;
        chk("er_score_x", 32'(sx3), 32'd0);
        tk();
        chk("er_turn_x", 32'(st3), 32'd1);

        // Game 2: draw
        p3(0); p3(1); p3(2); p3(4); p3(3);
        p3(5); p3(7); p3(6); p3(8);
        chk("dr_state", 32'(st3), 32'd6);
        chk("dr_disp", 32'(de3), 32'd1);
        chk("dr_x", 32'(x3), 32'h18D);
        chk("dr_o", 32'(o3), 32'h072);
        chk("dr_scores", 32'({sx3, so3}), 32'd0);

        // Timeout auto-placement for O
        erase = 1'b1;
        tk();
        erase = 1'b0;
        tk();
        p3(0); p3(5); p3(1);
        repeat (9) tk();
        chk("to_wait_state", 32'(st3), 32'd2);
        chk("to_wait_o", 32'(o3), 32'h020);
        tk();
        chk("to_fire_state", 32'(st3), 32'd3);
        chk("to_fire_o", 32'(o3), 32'h024);
        chk("to_fire_auto", 32'(am3), 32'd1);
        tk();
        chk("to_after_auto", 32'(am3), 32'd0);
        chk("to_after_state", 32'(st3), 32'd1);

        // Occupied press ignored; simultaneous rising edges take the lowest
        c3 = 9'b000000001;
        tk();
        chk("oc_state", 32'(st3), 32'd1);
        chk("oc_x", 32'(x3), 32'h003);
        c3 = 9'b001001001;
        tk();
        chk("mr_x", 32'(x3), 32'h00B);
        chk("mr_o", 32'(o3), 32'h024);
        c3 = '0;
        tk();
        chk("mr_turn_o", 32'(st3), 32'd2);

        // randomClick places on the very next tick
        rnd = 1'b1;
        tk();
        rnd = 1'b0;
        chk("rc_state", 32'(st3), 32'd3);
        chk("rc_o", 32'(o3), 32'h034);
        chk("rc_auto", 32'(am3), 32'd1);

        // 4x4 engine: anti-diagonal wins, score saturates at 3
        rst3 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        for (int r = 0; r < 4; r++) begin
            tk();
            if (r % 2 == 0) begin
                p4(3); p4(0); p4(6); p4(1); p4(9); p4(2); p4(12);
            end else begin
                p4(0); p4(3); p4(1); p4(6); p4(2); p4(9); p4(4); p4(12);
            end
            chk($sformatf("n4_r%0d_state", r), 32'(st4), 32'd4);
            chk($sformatf("n4_r%0d_x", r), 32'(x4), 32'h1248);
            chk($sformatf("n4_r%0d_score", r), 32'(sx4), (r < 3) ? r + 1 : 3);
            restart = 1'b1;
            tk();
            restart = 1'b0;
        end

        // Asynchronous reset in the middle of a turn
        tk();
        chk("n4_turn_x", 32'(st4), 32'd1);
        c4 = 16'h0008;
        tk();
        c4 = '0;
        chk("n4_mid_x", 32'(x4), 32'h0008);
        @(negedge clk);
        #2;
        rst4 = 1'b0;
        #1;
        chk("ar_state", 32'(st4), 32'd0);
        chk("ar_board", 32'({x4, o4}), 32'd0);
        chk("ar_score", 32'({sx4, so4}), 32'd0);
        chk("ar_start", 32'(dsp4), 32'd1);
        chk("ar_turnoX", 32'(tx4), 32'd1);
        chk("ar_auto", 32'(am4), 32'd0);
        chk("ar_disp", 32'({dgx4, dgo4, de4}), 32'd0);

        #20;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gato_nxn_engine.md
Name: gato_nxn_engine

Overview:
- Parametrised successor to the 3x3 tic-tac-toe machine: N x N board, full-line win (rows, columns, both diagonals), integrated X/O board registers, score counters, alternating first player, and a per-turn move timeout with automatic placement.
- Runs on the 100 MHz clock with a game-tick enable; it replaces the separate FSM and board-register instances under the game top level.
- The debounced square inputs arrive from the existing debouncer.

Parameters:
N, 3, board side; board holds N*N squares, index = row*N + col
SCORE_W, 4, width of each score counter (saturating)
TIMEOUT_TICKS, 10, ticks allowed per turn before auto-placement (>=1)
TMR_W, 4, width of turn timer; must hold TIMEOUT_TICKS

Ports:
clk_100MHz  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-cycle game-tick enable; all state updates occur only on cycles with tick=1
restart  in  1  level, sampled on tick: start new round, scores kept
erase  in  1  level, sampled on tick: clear board and both scores
randomClick  in  1  level, sampled on tick: force immediate auto-placement for the current player
cuadro  in  N*N  debounced square-select switches
x  out  N*N  squares held by X
o  out  N*N  squares held by O
state  out  3  encoded FSM state
turnoX  out  1  1 while it is X's turn
displayStartPlaying  out  1  1 in START
displayGanadorX / displayGanadorO / displayEmpate  out  1 each  1 in WIN_X / WIN_O / DRAW
score_x, score_o  out  SCORE_W each  round wins
auto_move  out  1  1 for the tick in which a placement was automatic

Behaviour:
- Reset (reset=0, async): x=o=0, scores=0, state=START, starter=X, timer=0, cuadro sample register=0, all display outputs 0 except displayStartPlaying=1, turnoX=1.
- States and encodings: START=0, TURN_X=1, TURN_O=2, CHECK=3, WIN_X=4, WIN_O=5, DRAW=6. Unused encodings return to START on the next tick.
- Priority on each tick, in any state: erase, then restart, then normal operation.
  - erase: board cleared, scores cleared, starter=X, state=START.
  - restart: board cleared, scores kept, state=START.
- START: next tick goes to TURN_X if starter=X, else TURN_O; timer=0.
- Move detection in TURN_*:
  - prev <= cuadro on every tick.
  - candidates = cuadro & ~prev & ~(x|o).
  - If candidates are nonzero, set the lowest-index candidate bit in the mover's board, then go to CHECK. Any other rising bits are discarded.
  - A rising edge on an occupied square is ignored.
- Auto-placement in TURN_*: triggers if randomClick=1, or if there are no candidates and the timer has reached TIMEOUT_TICKS-1. It sets the lowest-index free square, pulses auto_move, and goes to CHECK. Otherwise the timer increments.
- CHECK (one tick):
  - Evaluate the mover's board for any complete row, column, or diagonal.
  - Win: go to WIN_X / WIN_O and increment that score, saturating at 2^SCORE_W-1.
  - Else, if the board is full (x|o all ones): go to DRAW.
  - Else: go to the other player's turn with timer=0.
- turnoX: 1 in TURN_X; 0 in TURN_O; in CHECK it reflects the player who just moved.
- WIN_X, WIN_O, DRAW hold until restart or erase. Board and outputs stay frozen.
- Round end: starter toggles when leaving any terminal state via restart, so rounds alternate first player. erase forces starter=X.
- Invariant: x & o == 0 always; a bench assertion checks it.
- Latency: a move registers one tick after the edge sample; the result is visible after one CHECK tick.
- cuadro is not re-synchronised here; it must already be debounced and synchronous to clk_100MHz.

Decomposition:
- Package gato_pkg holds:
  - the state enum/localparams (START..DRAW);
  - a function that builds line masks for N (N rows, N columns, 2 diagonals = 2N+2 masks of N*N bits).
- Sub-module gato_line_check (parameter N): combinational; input board[N*N]; output win = OR over masks of (board & mask)==mask. Instantiated once and fed the mover's board.
- Priority-encoder logic for lowest-set-bit stays local.

Test Plan:
- N=3, reset then tick. X presses square 0, O presses 4, X presses 1, O presses 5, X presses 2 -> after the CHECK tick state=WIN_X, x=9'b000000111, score_x=1, displayGanadorX=1.
- Draw sequence X:0,O:1,X:2,O:4,X:3,O:5,X:7,O:6,X:8 -> state=DRAW, displayEmpate=1, scores unchanged.
- In TURN_O with squares 0 and 1 occupied, O idles TIMEOUT_TICKS ticks -> square 2 set in o, auto_move=1 for one tick. Repeat with randomClick=1 -> placement on the very next tick.
- Press an occupied square, then press square 3 and square 6 on the same tick -> occupied press ignored; only bit 3 is taken.
- After WIN_X, assert restart -> board 0, START, then TURN_O (starter toggled), score_x still 1. Assert erase together with restart -> scores 0, next turn TURN_X.
- N=4, SCORE_W=2: X wins the anti-diagonal (3,6,9,12) four rounds running -> score_x saturates at 3. Assert reset low mid-turn -> all outputs at reset values immediately, without waiting for a clock edge.
